atomik_core_v2: RTL and testbench

//  XOR delta-accumulation state core. Holds a loaded initial state and an

---
 rtl/atomik_core_v2.sv | 108 ++++++++++
 tb/tb_atomik_core_v2.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/atomik_core_v2.sv
// XOR delta-accumulation state core.
// Holds a loaded initial state plus an XOR accumulator of deltas and rebuilds
// current state = initial ^ accumulator on READ. Re-applying the same deltas
// cancels them, which gives rollback for free.
// Optional feature macro: ATOMIK_DELTA_COUNT_EN adds a saturating delta_count.
module atomik_core_v2 #(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             operation,
    input  logic [DATA_WIDTH-1:0]  data_in,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   data_valid,
    output logic                   accumulator_zero,
    output logic [DATA_WIDTH-1:0]  debug_initial_state,
    output logic [DATA_WIDTH-1:0]  debug_accumulator
`ifdef ATOMIK_DELTA_COUNT_EN
    ,
    output logic [COUNT_WIDTH-1:0] delta_count
`endif
);

    typedef enum logic [1:0] {
        OpNop  = 2'b00,
        OpLoad = 2'b01,
        OpAcc  = 2'b10,
        OpRead = 2'b11
    } op_e;

    op_e                   op;
    logic [DATA_WIDTH-1:0] init_q, init_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  valid_q, valid_d;

    assign op = op_e'(operation);

    // Next-state decode for the state, accumulator and read-out registers.
    always_comb begin
        init_d  = init_q;
        acc_d   = acc_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        unique case (op)
            OpNop:  ;
            OpLoad: begin
                init_d = data_in;
                acc_d  = '0;
            end
            OpAcc:  acc_d = acc_q ^ data_in;
            OpRead: begin
                // Uses pre-edge register values, so a READ never sees its own cycle.
                dout_d  = init_q ^ acc_q;
                valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            init_q  <= '0;
            acc_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            init_q  <= init_d;
            acc_q   <= acc_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
        end
    end

    assign data_out            = dout_q;
    assign data_valid          = valid_q;
    assign accumulator_zero    = (acc_q == '0);
    assign debug_initial_state = init_q;
    assign debug_accumulator   = acc_q;

`ifdef ATOMIK_DELTA_COUNT_EN
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

    // Delta counter: cleared by LOAD, saturates at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (op == OpLoad) begin
            cnt_d = '0;
        end else if (op == OpAcc && cnt_q != '1) begin
            cnt_d = cnt_q + COUNT_WIDTH'(1);
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign delta_count = cnt_q;
`endif

endmodule

// File: tb/tb_atomik_core_v2.sv
// Self-checking bench for atomik_core_v2: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_atomik_core_v2;

    localparam int unsigned DW = 64;
    localparam int unsigned CW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    operation = 2'b00;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          accumulator_zero;
    logic [DW-1:0] debug_initial_state;
    logic [DW-1:0] debug_accumulator;
`ifdef ATOMIK_DELTA_COUNT_EN
    logic [CW-1:0] delta_count;
`endif

    atomik_core_v2 #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .operation           (operation),
        .data_in             (data_in),
        .data_out            (data_out),
        .data_valid          (data_valid),
        .accumulator_zero    (accumulator_zero),
        .debug_initial_state (debug_initial_state),
        .debug_accumulator   (debug_accumulator)
`ifdef ATOMIK_DELTA_COUNT_EN
        ,
        .delta_count         (delta_count)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural model: state, running XOR of deltas since LOAD, last read.
    logic [DW-1:0] m_init = '0;
    logic [DW-1:0] m_acc  = '0;
    logic [DW-1:0] m_out  = '0;
    logic          m_valid = 1'b0;
    longint        m_cnt  = 0;
    bit            chk_en = 1'b0;

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at %0t: got 0x%h expected 0x%h", name, $time, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] sat_cnt(input longint n);
        longint maxv = (longint'(1) << CW) - 1;
        return CW'((n > maxv) ? maxv : n);
    endfunction

    // Apply one operation for one clock edge and advance the model.
    task automatic step(input logic r, input logic [1:0] op, input logic [DW-1:0] d);
        rst_n     = r;
        operation = op;
        data_in   = d;
        @(posedge clk);
        #1;
        if (!r) begin
            m_init = '0; m_acc = '0; m_out = '0; m_valid = 1'b0; m_cnt = 0;
        end else begin
            m_valid = 1'b0;
            case (op)
                2'b01: begin m_init = d; m_acc = '0; m_cnt = 0; end
                2'b10: begin m_acc = m_acc ^ d; m_cnt = m_cnt + 1; end
                2'b11: begin m_out = m_init ^ m_acc; m_valid = 1'b1; end
                default: ;
            endcase
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("data_out", data_out, m_out);
            chk("data_valid", DW'(data_valid), DW'(m_valid));
            chk("accumulator_zero", DW'(accumulator_zero), DW'(m_acc == '0));
            chk("debug_initial_state", debug_initial_state, m_init);
            chk("debug_accumulator", debug_accumulator, m_acc);
`ifdef ATOMIK_DELTA_COUNT_EN
            chk("delta_count", DW'(delta_count), DW'(sat_cnt(m_cnt)));
`endif
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0]   f;
        logic [DW-1:0] d;
        logic [1:0]    op;

        step(1'b0, 2'b00, '0);
        step(1'b0, 2'b00, '0);
        chk_en = 1'b1;
        chk("reset data_out", data_out, 64'h0);
        chk("reset data_valid", DW'(data_valid), 64'h0);
        chk("reset accumulator_zero", DW'(accumulator_zero), 64'h1);

        // 1: plain load
        step(1'b1, 2'b01, 64'h0000_0100_0000_0000);
        chk("t1 initial", debug_initial_state, 64'h0000_0100_0000_0000);
        chk("t1 acc", debug_accumulator, 64'h0);
        chk("t1 acc_zero", DW'(accumulator_zero), 64'h1);

        // 2: 100 back-to-back deltas
        step(1'b1, 2'b01, 64'hDEADBEEFCAFEBABE);
        for (int i = 1; i <= 100; i++) step(1'b1, 2'b10, DW'(i));
        chk("t2 acc", debug_accumulator, 64'h64);
        step(1'b1, 2'b11, '0);
        chk("t2 read", data_out, 64'hDEADBEEFCAFEBADA);
        chk("t2 valid", DW'(data_valid), 64'h1);
        step(1'b1, 2'b00, '0);
        chk("t2 valid pulse", DW'(data_valid), 64'h0);
        chk("t2 hold", data_out, 64'hDEADBEEFCAFEBADA);

        // 3: bit-pattern deltas
        step(1'b1, 2'b01, 64'hAAAA5555AAAA5555);
        step(1'b1, 2'b10, 64'h0000FFFF0000FFFF);
        step(1'b1, 2'b10, 64'hFFFF0000FFFF0000);
        step(1'b1, 2'b10, 64'h123456789ABCDEF0);
        step(1'b1, 2'b11, '0);
        chk("t3 read", data_out, 64'h4761FCD2CFE9745A);

        // 4: 4096 packed deltas, then reapplied for rollback
        step(1'b1, 2'b01, 64'hFEEDFACE0BADCAFE);
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 4096; i++) begin
                f = 16'(i);
                step(1'b1, 2'b10, {f, f ^ 16'hA5A5, f ^ 16'h5A5A, ~f});
            end
            step(1'b1, 2'b11, '0);
        end
        chk("t4 acc_zero", DW'(accumulator_zero), 64'h1);
        chk("t4 rollback read", data_out, 64'hFEEDFACE0BADCAFE);

        // 5: packed price/volume/flags fields
        step(1'b1, 2'b01, 64'h000100000100000F);
        step(1'b1, 2'b10, 64'h0000000500030001);
        step(1'b1, 2'b10, 64'h0000000A00070002);
        step(1'b1, 2'b11, '0);
        chk("t5 read", data_out, 64'h0001000F0104000C);

        // 6: reset in the middle of a burst
        step(1'b1, 2'b01, 64'h0123456789ABCDEF);
        for (int i = 0; i < 5; i++) step(1'b1, 2'b10, {$urandom, $urandom});
        step(1'b1, 2'b11, '0);
`ifdef ATOMIK_DELTA_COUNT_EN
        chk("t6 delta_count", DW'(delta_count), 64'd5);
`endif
        step(1'b0, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t6 rst initial", debug_initial_state, 64'h0);
        chk("t6 rst acc", debug_accumulator, 64'h0);
        chk("t6 rst data_out", data_out, 64'h0);
        chk("t6 rst valid", DW'(data_valid), 64'h0);
`ifdef ATOMIK_DELTA_COUNT_EN
        chk("t6 rst delta_count", DW'(delta_count), 64'd0);
`endif

        // Randomized traffic, occasional reset
        for (int i = 0; i < 2000; i++) begin
            op = 2'($urandom_range(0, 3));
            d  = {$urandom, $urandom};
            step(($urandom_range(0, 99) != 0), op, d);
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
